rtc_bus_reader: RTL and testbench
=================================

// Module: rtc_bus_reader
// PURPOSE
//  Read-cycle controller for the RTC's multiplexed 8-bit address/data bus.
//  Runs one complete read transaction: drives the register address with an A/D-low
//  write strobe, releases the bus, asserts RD, then samples the data the RTC returns.
//  bus_out/bus_oe feed the existing tristate bus buffer (its in/EN_SS).
//  bus_in is the read-back of RTC_BUS.
// PARAMETERS
//  T_SU  2  setup cycles: CS/AD and address valid before the strobe (range 1..255)
//  T_PW  4  WR and RD strobe low width, in cycles (range 1..255)
//  T_HD  2  hold cycles after the strobe rises, before the next phase (range 1..255)
//  T_TA  2  bus turnaround cycles, bus released and CS high, between phases (range 1..255)
// PORTS
//  clk      in   1  system clock; all state changes on its rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  start    in   1  request a read; sampled only in IDLE
//  addr     in   8  RTC register address; latched when start is accepted
//  bus_in   in   8  RTC_BUS read-back
//  bus_out  out  8  address to drive onto RTC_BUS (buffer data input)
//  bus_oe   out  1  buffer drive enable (EN_SS); 1 = drive RTC_BUS
//  cs_n     out  1  RTC chip select, active-low
//  ad_n     out  1  0 = address phase, 1 = data phase
//  wr_n     out  1  RTC write strobe, active-low
//  rd_n     out  1  RTC read strobe, active-low
//  rd_data  out  8  last sampled data byte; holds its value between reads
//  busy     out  1  1 in every state except IDLE
//  done     out  1  one-cycle pulse; rd_data is valid in the same cycle
// BEHAVIOUR
//  - All outputs are registered and decoded from the state entered at each edge.
//  - Reset values: cs_n=ad_n=wr_n=rd_n=1, bus_oe=0, bus_out=0, rd_data=0, busy=0, done=0,
//    state=IDLE, phase counter=0.
//  - Phase counter: 8-bit, loaded with N-1 on entry to an N-cycle phase, decrements each cycle.
//    The state advances on the edge where the counter is 0, so each phase lasts exactly N cycles.
//  - Output levels per state:
//    IDLE     cs_n=1 ad_n=1 wr_n=1 rd_n=1 bus_oe=0. On start=1: latch addr, go to A_SU.
//    A_SU     (T_SU cycles) cs_n=0 ad_n=0 bus_oe=1 bus_out=addr
//    A_WR     (T_PW cycles) as A_SU, plus wr_n=0
//    A_HD     (T_HD cycles) wr_n=1; bus still driven, cs_n=0, ad_n=0
//    TURN     (T_TA cycles) bus_oe=0 cs_n=1 ad_n=1; bus_out holds its value
//    D_SU     (T_SU cycles) cs_n=0 ad_n=1 bus_oe=0
//    D_RD     (T_PW cycles) rd_n=0; rd_data<=bus_in on the edge that leaves D_RD
//    D_HD     (T_HD cycles) rd_n=1, cs_n=0
//    DONE     (1 cycle) done=1 cs_n=1 busy=1, then IDLE
//  - Latency: start accepted at edge k -> done high in cycle k+1+2*T_SU+2*T_PW+2*T_HD+T_TA
//    (k+19 with defaults). Consecutive starts are separated by at least one IDLE cycle.
//  - Invariants: bus_oe=1 never coincides with rd_n=0. wr_n and rd_n are never low together.
//    Strobes are only low while cs_n=0.
//  - start while busy (including the DONE cycle) is ignored and not queued.
//  - addr changes after acceptance have no effect on the running transaction.
//  - rst_n low at any point: all outputs return to reset values immediately (asynchronously).
//    No done pulse is produced, and rd_data is cleared to 0.
//  - The bus_in value is captured as-is; no parity or validity checking is performed.
// TESTING
//  1 rst_n=0 mid-idle -> cs_n/ad_n/wr_n/rd_n=1, bus_oe=0, rd_data=8'h00, busy=0, done=0
//  2 start, addr=8'h21; RTC model drives 8'h29 while rd_n=0 -> bus_out=8'h21 with bus_oe=1 during wr_n=0;
//    rd_data=8'h29; done exactly 1 cycle, 19 cycles after the start edge
//  3 start again, addr=8'h22, 3 cycles into a read -> ignored; transaction completes with addr 21;
//    a later start with addr=8'h22 and model data 8'h16 -> rd_data=8'h16
//  4 rst_n pulsed low during D_RD -> rd_n/cs_n go high without a clock edge, no done, rd_data=0;
//    next start completes normally
//  5 continuous assertions over all tests: never (bus_oe & ~rd_n); never (~wr_n & ~rd_n);
//    at least T_TA cycles with bus_oe=0 before rd_n falls
//  6 start held high continuously, T_PW=1, T_TA=1 -> back-to-back reads with exactly one IDLE cycle between done and the next cs_n=0

Source files
------------

// File: rtl/rtc_bus_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rtc_bus_reader
// -----------------------------------------------------------------------------
// Read-cycle controller for the RTC's multiplexed 8-bit address/data bus.
//
// A complete read has two halves:
// - Address half: the address is driven onto the bus and strobed with WR while
//   AD is low.
// - Data half: after a bus turnaround, RD is strobed while AD is high. The
//   byte the RTC returns is sampled on the edge that ends the RD strobe.
//
// Every phase has a programmable length in clock cycles.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    read request, only looked at while idle
//   addr     RTC register address, captured when start is accepted
//   bus_in   read-back of RTC_BUS
//   bus_out  address for the tristate buffer data input
//   bus_oe   tristate buffer enable (1 = drive RTC_BUS)
//   cs_n     RTC chip select, active-low
//   ad_n     0 = address phase, 1 = data phase
//   wr_n     RTC write strobe, active-low
//   rd_n     RTC read strobe, active-low
//   rd_data  last byte read; holds between reads, cleared by reset
//   busy     high whenever a transaction is in progress (incl. DONE)
//   done     one-cycle pulse, rd_data valid in the same cycle
//
// Parameters (cycles, each 1..255)
//   T_SU  setup before each strobe
//   T_PW  WR / RD strobe width
//   T_HD  hold after each strobe
//   T_TA  turnaround with bus released and CS high
// -----------------------------------------------------------------------------
module rtc_bus_reader #(
    parameter int T_SU = 2,
    parameter int T_PW = 4,
    parameter int T_HD = 2,
    parameter int T_TA = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done
);

    // Phase counters are loaded with length-1 so that a phase ends on the
    // edge where the counter reads zero.
    localparam logic [7:0] SU_M1 = 8'(T_SU - 1);
    localparam logic [7:0] PW_M1 = 8'(T_PW - 1);
    localparam logic [7:0] HD_M1 = 8'(T_HD - 1);
    localparam logic [7:0] TA_M1 = 8'(T_TA - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SU,
        S_A_WR,
        S_A_HD,
        S_TURN,
        S_D_SU,
        S_D_RD,
        S_D_HD,
        S_DONE
    } state_t;

    state_t     state_reg,   state_next;
    logic [7:0] cnt_reg,     cnt_next;
    logic [7:0] bus_out_reg, bus_out_next;
    logic [7:0] rd_data_reg, rd_data_next;
    logic       bus_oe_reg,  bus_oe_next;
    logic       cs_n_reg,    cs_n_next;
    logic       ad_n_reg,    ad_n_next;
    logic       wr_n_reg,    wr_n_next;
    logic       rd_n_reg,    rd_n_next;
    logic       busy_reg,    busy_next;
    logic       done_reg,    done_next;

    logic       phase_end;

    assign phase_end = (cnt_reg == 8'd0);

    // Next state and phase counter
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_A_SU;
                    cnt_next   = SU_M1;
                end
            end
            S_A_SU: begin
                if (phase_end) begin
                    state_next = S_A_WR;
                    cnt_next   = PW_M1;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            S_A_WR: begin
                if (phase_end) begin
                    state_next = S_A_HD;
                    cnt_next   = HD_M1;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            S_A_HD: begin
                if (phase_end) begin
                    state_next = S_TURN;
                    cnt_next   = TA_M1;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            S_TURN: begin
                if (phase_end) begin
                    state_next = S_D_SU;
                    cnt_next   = SU_M1;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            S_D_SU: begin
                if (phase_end) begin
                    state_next = S_D_RD;
                    cnt_next   = PW_M1;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            S_D_RD: begin
                if (phase_end) begin
                    state_next = S_D_HD;
                    cnt_next   = HD_M1;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            S_D_HD: begin
                if (phase_end) begin
                    state_next = S_DONE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here: a request during
                // DONE is dropped, which guarantees one IDLE cycle between reads.
                state_next = S_IDLE;
                cnt_next   = 8'd0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Output levels are decoded from the state being entered, so every
    // output register changes on the same edge as the state register.
    always_comb begin
        bus_oe_next = (state_next == S_A_SU) || (state_next == S_A_WR) ||
                      (state_next == S_A_HD);
        ad_n_next   = !bus_oe_next;
        cs_n_next   = (state_next == S_IDLE) || (state_next == S_TURN) ||
                      (state_next == S_DONE);
        wr_n_next   = (state_next != S_A_WR);
        rd_n_next   = (state_next != S_D_RD);
        busy_next   = (state_next != S_IDLE);
        done_next   = (state_next == S_DONE);

        // bus_out doubles as the latched address; it is loaded only when a
        // request is accepted and otherwise keeps its value.
        bus_out_next = bus_out_reg;
        if ((state_reg == S_IDLE) && start) begin
            bus_out_next = addr;
        end

        // Sample on the edge that ends the RD strobe.
        rd_data_next = rd_data_reg;
        if ((state_reg == S_D_RD) && phase_end) begin
            rd_data_next = bus_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 8'd0;
            bus_out_reg <= 8'd0;
            rd_data_reg <= 8'd0;
            bus_oe_reg  <= 1'b0;
            cs_n_reg    <= 1'b1;
            ad_n_reg    <= 1'b1;
            wr_n_reg    <= 1'b1;
            rd_n_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bus_out_reg <= bus_out_next;
            rd_data_reg <= rd_data_next;
            bus_oe_reg  <= bus_oe_next;
            cs_n_reg    <= cs_n_next;
            ad_n_reg    <= ad_n_next;
            wr_n_reg    <= wr_n_next;
            rd_n_reg    <= rd_n_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign bus_out = bus_out_reg;
    assign bus_oe  = bus_oe_reg;
    assign cs_n    = cs_n_reg;
    assign ad_n    = ad_n_reg;
    assign wr_n    = wr_n_reg;
    assign rd_n    = rd_n_reg;
    assign rd_data = rd_data_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_rtc_bus_reader.sv
`timescale 1ns/1ps
// Testbench for rtc_bus_reader.
// - Instance 0 uses default timing.
// - Instance 1 uses T_PW=1, T_TA=1 and runs back-to-back reads.
//
// The reference model tracks each transaction as a cycle index t:
// - t = 0 is idle.
// - Cycle 1 is the first cycle after the accepting edge.
// - The expected bus levels follow from which timing window t falls in.
module tb_rtc_bus_reader;

    localparam int SU_P [2] = '{2, 2};
    localparam int PW_P [2] = '{4, 1};
    localparam int HD_P [2] = '{2, 2};
    localparam int TA_P [2] = '{2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v   [2];
    logic [7:0] addr_v    [2];
    logic [7:0] bus_in_v  [2];
    logic [7:0] rtc_data_v[2];
    logic [7:0] bus_out_v [2];
    logic [7:0] rd_data_v [2];
    logic       bus_oe_v  [2];
    logic       cs_n_v    [2];
    logic       ad_n_v    [2];
    logic       wr_n_v    [2];
    logic       rd_n_v    [2];
    logic       busy_v    [2];
    logic       done_v    [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rtc_bus_reader #(.T_SU(SU_P[0]), .T_PW(PW_P[0]), .T_HD(HD_P[0]), .T_TA(TA_P[0])) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .addr(addr_v[0]), .bus_in(bus_in_v[0]),
        .bus_out(bus_out_v[0]), .bus_oe(bus_oe_v[0]), .cs_n(cs_n_v[0]), .ad_n(ad_n_v[0]),
        .wr_n(wr_n_v[0]), .rd_n(rd_n_v[0]), .rd_data(rd_data_v[0]), .busy(busy_v[0]),
        .done(done_v[0])
    );

    rtc_bus_reader #(.T_SU(SU_P[1]), .T_PW(PW_P[1]), .T_HD(HD_P[1]), .T_TA(TA_P[1])) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .addr(addr_v[1]), .bus_in(bus_in_v[1]),
        .bus_out(bus_out_v[1]), .bus_oe(bus_oe_v[1]), .cs_n(cs_n_v[1]), .ad_n(ad_n_v[1]),
        .wr_n(wr_n_v[1]), .rd_n(rd_n_v[1]), .rd_data(rd_data_v[1]), .busy(busy_v[1]),
        .done(done_v[1])
    );

    // RTC model: returns its data byte only while RD is low, junk otherwise.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bus_in_v[i] = (rd_n_v[i] == 1'b0) ? rtc_data_v[i] : 8'hA5;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_t   [2] = '{0, 0};
    logic [7:0] m_addr[2] = '{8'h00, 8'h00};
    logic [7:0] m_rd  [2] = '{8'h00, 8'h00};

    function automatic int total_len(input int i);
        return 2 * SU_P[i] + 2 * PW_P[i] + 2 * HD_P[i] + TA_P[i];
    endfunction

    // Last cycle of the RD strobe window.
    function automatic int rd_end(input int i);
        return 2 * SU_P[i] + 2 * PW_P[i] + HD_P[i] + TA_P[i];
    endfunction

    // 0..6 = timing window within the read, 7 = done cycle.
    function automatic int window_of(input int i, input int t);
        int d[7];
        int acc;
        d = '{SU_P[i], PW_P[i], HD_P[i], TA_P[i], SU_P[i], PW_P[i], HD_P[i]};
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            acc += d[k];
            if (t <= acc) return k;
        end
        return 7;
    endfunction

    // {cs_n, ad_n, wr_n, rd_n, bus_oe, busy, done}
    function automatic logic [6:0] exp_ctrl(input int w);
        case (w)
            0, 2:    return 7'b0011110;
            1:       return 7'b0001110;
            3:       return 7'b1111010;
            4, 6:    return 7'b0111010;
            5:       return 7'b0110010;
            7:       return 7'b1111011;
            default: return 7'b1111000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_t[i]    <= 0;
                m_addr[i] <= 8'h00;
                m_rd[i]   <= 8'h00;
            end else if (m_t[i] == 0) begin
                if (start_v[i]) begin
                    m_t[i]    <= 1;
                    m_addr[i] <= addr_v[i];
                end
            end else if (m_t[i] > total_len(i)) begin
                m_t[i] <= 0;
            end else begin
                if (m_t[i] == rd_end(i)) m_rd[i] <= rtc_data_v[i];
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    // ---------------- per-cycle compare and invariants ----------------
    int   oe_low_cnt[2] = '{0, 0};
    logic prev_rd_n [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        int w;
        for (int i = 0; i < 2; i++) begin
            w = (m_t[i] == 0) ? 8 : window_of(i, m_t[i]);
            check($sformatf("ctrl%0d", i),
                  {25'd0, cs_n_v[i], ad_n_v[i], wr_n_v[i], rd_n_v[i], bus_oe_v[i], busy_v[i], done_v[i]},
                  {25'd0, exp_ctrl(w)});
            check($sformatf("bus_out%0d", i), {24'd0, bus_out_v[i]}, {24'd0, m_addr[i]});
            check($sformatf("rd_data%0d", i), {24'd0, rd_data_v[i]}, {24'd0, m_rd[i]});
            check($sformatf("inv_oe_rd%0d", i), {31'd0, bus_oe_v[i] & ~rd_n_v[i]}, 32'd0);
            check($sformatf("inv_wr_rd%0d", i), {31'd0, ~wr_n_v[i] & ~rd_n_v[i]}, 32'd0);
            check($sformatf("inv_strobe_cs%0d", i), {31'd0, (~wr_n_v[i] | ~rd_n_v[i]) & cs_n_v[i]}, 32'd0);
            if (prev_rd_n[i] && !rd_n_v[i]) begin
                check($sformatf("turnaround%0d", i), {31'd0, oe_low_cnt[i] >= TA_P[i]}, 32'd1);
            end
            oe_low_cnt[i] = bus_oe_v[i] ? 0 : oe_low_cnt[i] + 1;
            prev_rd_n[i]  = rd_n_v[i];
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at the sampling point of cycle 1 of a transaction on instance 0.
    // Optionally re-requests (with another address) at cycle inj_cyc.
    task automatic watch_txn(input string tag, input logic [7:0] exp_addr, input logic [7:0] exp_data,
                             input int exp_lat, input int inj_cyc, input logic [7:0] inj_addr);
        int done_cyc;
        int done_cnt;
        done_cyc = -1;
        done_cnt = 0;
        for (int cyc = 1; cyc <= exp_lat + 4; cyc++) begin
            if (!wr_n_v[0]) begin
                check({tag, "_wr_addr"}, {24'd0, bus_out_v[0]}, {24'd0, exp_addr});
                check({tag, "_wr_oe"}, {31'd0, bus_oe_v[0]}, 32'd1);
            end
            if (done_v[0]) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({tag, "_data"}, {24'd0, rd_data_v[0]}, {24'd0, exp_data});
                end
            end else if (done_cyc > 0) begin
                check({tag, "_idle_after"}, {31'd0, busy_v[0]}, 32'd0);
            end
            if (cyc == inj_cyc) begin
                start_v[0] = 1'b1;
                addr_v[0]  = inj_addr;
            end else begin
                start_v[0] = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_latency"}, done_cyc, exp_lat);
        check({tag, "_done_width"}, done_cnt, 1);
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] d);
        addr_v[0]     = a;
        rtc_data_v[0] = d;
        start_v[0]    = 1'b1;
        @(negedge clk);
        start_v[0]    = 1'b0;
    endtask

    initial begin
        int d1;
        int cs_after;
        int d2;
        bit found;
        bit prev_done;
        for (int i = 0; i < 2; i++) begin
            start_v[i]    = 1'b0;
            addr_v[i]     = 8'h00;
            rtc_data_v[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_ctrl", {cs_n_v[0], ad_n_v[0], wr_n_v[0], rd_n_v[0], bus_oe_v[0], busy_v[0], done_v[0]}, 7'b1111000);
        check("rst_rd_data", rd_data_v[0], 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Test 1: reset while idle
        #1 rst_n = 1'b0;
        #1 check("t1_ctrl", {cs_n_v[0], ad_n_v[0], wr_n_v[0], rd_n_v[0], bus_oe_v[0], busy_v[0], done_v[0]}, 7'b1111000);
        check("t1_rd_data", rd_data_v[0], 8'h00);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Test 2: plain read, done 19 cycles after the start edge
        launch(8'h21, 8'h29);
        watch_txn("t2", 8'h21, 8'h29, 19, 0, 8'h00);
        repeat (2) @(negedge clk);

        // Test 3: start with another address 3 cycles in is ignored
        launch(8'h21, 8'h29);
        watch_txn("t3a", 8'h21, 8'h29, 19, 3, 8'h22);
        launch(8'h22, 8'h16);
        watch_txn("t3b", 8'h22, 8'h16, 19, 0, 8'h00);
        check("t3_rd_hold", rd_data_v[0], 8'h16);

        // Test 4: asynchronous reset while RD is low
        launch(8'h5A, 8'h77);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (!rd_n_v[0]) found = 1'b1;
            else @(negedge clk);
        end
        check("t4_reached_rd", found, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("t4_rd_n", rd_n_v[0], 1'b1);
        check("t4_cs_n", cs_n_v[0], 1'b1);
        check("t4_rd_data", rd_data_v[0], 8'h00);
        check("t4_busy", busy_v[0], 1'b0);
        #1 rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done_v[0]) found = 1'b1;
        end
        check("t4_no_done", found, 1'b0);
        launch(8'h3C, 8'hC3);
        watch_txn("t4b", 8'h3C, 8'hC3, 19, 0, 8'h00);

        // Test 6: start held high on the short-timing instance
        addr_v[1]     = 8'h5E;
        rtc_data_v[1] = 8'hE5;
        start_v[1]    = 1'b1;
        @(negedge clk);
        d1 = -1; cs_after = -1; d2 = -1;
        prev_done = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done_v[1] && !prev_done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    check("t6_data", rd_data_v[1], 8'hE5);
                end else if (d2 < 0) begin
                    d2 = cyc;
                end
            end
            if (d1 > 0 && cyc > d1 && cs_after < 0 && !cs_n_v[1]) cs_after = cyc;
            prev_done = done_v[1];
            @(negedge clk);
        end
        start_v[1] = 1'b0;
        check("t6_latency", d1, 12);
        check("t6_gap", cs_after - d1, 2);
        check("t6_period", d2 - d1, 13);
        repeat (20) @(negedge clk);
        check("t6_idle_end", busy_v[1], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
